// File: rtl/alu_md.sv
// alu_md: execute-stage ALU (combinational) plus an iterative mul/div engine owning HI/LO.
// Latency: ALUResult/Zero/Overflow 0 cycles; MULT/MULTU/DIV/DIVU exactly WIDTH cycles; MTHI/MTLO 1 edge.
// Backpressure: Busy high while an iterative op runs; Start is ignored then, except at the finishing edge.
//
// Ports:
//   clk, reset (async, active-low)
//   SrcA, SrcB, ALUOp -> ALUResult, Zero, Overflow   (combinational ALU)
//   MDOp, Start       -> Busy, HI, LO                 (mul/div engine)
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] alu_res;
  logic             ovf;
  logic [SHW-1:0]   shamt;

  assign shamt = SrcA[SHW-1:0];

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (ALUOp)
      4'd0: alu_res = SrcA & SrcB;
      4'd1: alu_res = SrcA | SrcB;
      4'd2: begin
        alu_res = SrcA + SrcB;
        ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      4'd3: alu_res = SrcA ^ SrcB;
      4'd4: alu_res = ~(SrcA | SrcB);
      4'd5: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'd6: begin
        alu_res = SrcA - SrcB;
        ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      4'd8:  alu_res = SrcB << shamt;
      4'd9:  alu_res = SrcB >> shamt;
      4'd10: alu_res = $signed(SrcB) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  assign ALUResult = alu_res;
  assign Zero      = (alu_res == '0);
  assign Overflow  = ovf;

  // ---------------- mul/div engine ----------------
  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work_hi;   // MUL: partial product upper half; DIV: partial remainder
  logic [WIDTH-1:0] work_lo;   // MUL: multiplier / product lower half; DIV: dividend / quotient
  logic [WIDTH-1:0] mcand;     // MUL: |A| multiplicand; DIV: |B| divisor
  logic [WIDTH-1:0] a_raw;     // dividend as launched, returned on divide-by-zero
  logic             neg_res;   // negate product / quotient at the end
  logic             neg_rem;   // negate remainder at the end
  logic             div0;

  // Launch-side decode. A launch is legal from IDLE or on the finishing edge,
  // where it only loads the working registers while HI/LO take the old result.
  logic             last;
  logic             md_iter;
  logic             md_is_div;
  logic             md_signed;
  logic             launch;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign last      = (state != S_IDLE) && (cnt == LAST);
  assign md_iter   = (MDOp >= 3'd1) && (MDOp <= 3'd4);
  assign md_is_div = (MDOp == 3'd3) || (MDOp == 3'd4);
  assign md_signed = (MDOp == 3'd1) || (MDOp == 3'd3);
  assign launch    = Start && md_iter && ((state == S_IDLE) || last);
  assign a_neg     = md_signed && SrcA[WIDTH-1];
  assign b_neg     = md_signed && SrcB[WIDTH-1];
  assign mag_a     = a_neg ? ('0 - SrcA) : SrcA;
  assign mag_b     = b_neg ? ('0 - SrcB) : SrcB;

  // One iteration of each algorithm, evaluated from the current working state.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
    div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, mcand};
    nxt_hi    = '0;
    nxt_lo    = '0;
    prod      = '0;
    fin_hi    = '0;
    fin_lo    = '0;
    if (state == S_MUL) begin
      // shift {carry, hi, lo} right by one after the conditional add
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
      prod   = {nxt_hi, nxt_lo};
      if (neg_res) prod = '0 - prod;
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else begin
      // restoring step: keep the subtraction only if it did not borrow
      nxt_hi = div_trial[WIDTH] ? {work_hi[WIDTH-2:0], work_lo[WIDTH-1]} : div_trial[WIDTH-1:0];
      nxt_lo = {work_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      if (div0) begin
        fin_hi = a_raw;
        fin_lo = '1;
      end else begin
        fin_hi = neg_rem ? ('0 - nxt_hi) : nxt_hi;
        fin_lo = neg_res ? ('0 - nxt_lo) : nxt_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      work_hi <= '0;
      work_lo <= '0;
      mcand   <= '0;
      a_raw   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        cnt     <= cnt + 1'b1;
        work_hi <= nxt_hi;
        work_lo <= nxt_lo;
        if (last) begin
          HI    <= fin_hi;
          LO    <= fin_lo;
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      end else if (Start && MDOp == 3'd5) begin
        HI <= SrcA;
      end else if (Start && MDOp == 3'd6) begin
        LO <= SrcA;
      end
      // Later assignments win: a launch overrides the idle/step updates above.
      if (launch) begin
        state   <= md_is_div ? S_DIV : S_MUL;
        Busy    <= 1'b1;
        cnt     <= '0;
        work_hi <= '0;
        work_lo <= md_is_div ? mag_a : mag_b;
        mcand   <= md_is_div ? mag_b : mag_a;
        a_raw   <= SrcA;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        div0    <= md_is_div && (SrcB == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed + randomized self-checking bench for alu_md (WIDTH=32).
// Latency: n/a (testbench).
// Backpressure: polls Busy with a bounded cycle budget.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  ALUOp;
  logic [31:0] ALUResult;
  logic        Zero, Overflow;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .ALUOp(ALUOp),
    .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
    .MDOp(MDOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: plain arithmetic on the operand values.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a - b;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return 32'($signed(b) >>> a[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Overflow from the exact signed sum/difference falling outside 32-bit range.
  function automatic logic ovf_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd2)      s = sa + sb;
    else if (op == 4'd6) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference mul/div result as {HI, LO} using 64-bit integer arithmetic.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      3'd1: p = 64'(sa * sb);
      3'd2: p = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    ALUOp = op; SrcA = a; SrcB = b;
    #1;
    e = alu_ref(op, a, b);
    chk({tag, " res"}, ALUResult, e);
    chk({tag, " zero"}, Zero, (e == 32'd0));
    chk({tag, " ovf"}, Overflow, ovf_ref(op, a, b));
  endtask

  // Launch one iterative op, count Busy cycles, check hold and final HI/LO.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    logic [31:0] hi0, lo0;
    int n;
    bit leak;
    e = md_ref(op, a, b);
    hi0 = HI; lo0 = LO; leak = 0; n = 0;
    MDOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0; SrcA = $urandom; SrcB = $urandom;
    while (Busy && n < 200) begin
      n++;
      if (HI !== hi0 || LO !== lo0) leak = 1;
      step();
    end
    chk({tag, " busy_cycles"}, n, 32);
    chk({tag, " hold"}, leak, 0);
    chk({tag, " hi"}, HI, e[63:32]);
    chk({tag, " lo"}, LO, e[31:0]);
  endtask

  initial begin
    logic [31:0] r, a, b, hi0, lo0;
    logic [2:0]  op;
    int n;
    bit bad;

    reset = 1'b0; Start = 1'b0; MDOp = 3'd0; ALUOp = 4'd0; SrcA = '0; SrcB = '0;
    repeat (3) step();
    chk("rst hi", HI, 0);
    chk("rst lo", LO, 0);
    chk("rst busy", Busy, 0);
    reset = 1'b1;

    // Directed combinational cases
    alu_chk("add_ovf", 4'd2, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf const", {ALUResult, Overflow, Zero}, {32'h80000000, 1'b1, 1'b0});
    alu_chk("slt", 4'd5, 32'hFFFFFFFF, 32'h1);
    chk("slt const", ALUResult, 1);
    alu_chk("sltu", 4'd7, 32'hFFFFFFFF, 32'h1);
    chk("sltu const", ALUResult, 0);
    alu_chk("sra", 4'd10, 32'd4, 32'h80000000);
    chk("sra const", ALUResult, 32'hF8000000);
    alu_chk("sub_zero", 4'd6, 32'd5, 32'd5);
    chk("sub_zero const", Zero, 1);
    alu_chk("op13", 4'd13, 32'hDEADBEEF, 32'h12345678);
    chk("op13 const", ALUResult, 0);
    alu_chk("sub_ovf", 4'd6, 32'h80000000, 32'h1);

    // Randomized combinational ops
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      alu_chk("alu_rand", 4'($urandom_range(0, 15)), a, b);
    end
    ALUOp = 4'd0;

    // Multiply / divide directed
    run_md("mult", 3'd1, 32'hFFFFFFFF, 32'd2);
    chk("mult const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
    run_md("multu", 3'd2, 32'hFFFFFFFF, 32'd2);
    chk("multu const", {HI, LO}, 64'h00000001_FFFFFFFE);
    run_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_neg const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_md("div_min", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min const", {HI, LO}, 64'h00000000_80000000);
    run_md("divu_zero", 3'd4, 32'd7, 32'd0);
    chk("divu_zero const", {HI, LO}, 64'h00000007_FFFFFFFF);
    run_md("div_zero_s", 3'd3, 32'hFFFFFFF0, 32'd0);

    // Randomized mul/div
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_md("md_rand", op, a, b);
    end

    // MTHI / MTLO from idle, and NONE/reserved ops
    r = $urandom;
    MDOp = 3'd5; SrcA = r; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("mthi hi", HI, r);
    chk("mthi busy", Busy, 0);
    a = $urandom;
    MDOp = 3'd6; SrcA = a; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("mtlo lo", LO, a);
    chk("mtlo hi", HI, r);
    MDOp = 3'd7; SrcA = $urandom; Start = 1'b1;
    step();
    MDOp = 3'd0;
    step();
    Start = 1'b0;
    chk("none busy", Busy, 0);
    chk("none hilo", {HI, LO}, {r, a});

    // MTHI while busy is ignored
    MDOp = 3'd2; SrcA = 32'h0000FFFF; SrcB = 32'h10; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (5) step();
    MDOp = 3'd5; SrcA = 32'h1234; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    n = 0;
    while (Busy && n < 200) begin n++; step(); end
    chk("mthi_busy done", Busy, 0);
    chk("mthi_busy hi", HI, 32'h0);
    chk("mthi_busy lo", LO, 32'h000FFFF0);

    // Back-to-back: MULTU 3x4, then DIVU 9/2 accepted on the finishing edge
    MDOp = 3'd2; SrcA = 32'd3; SrcB = 32'd4; Start = 1'b1;
    step();                          // E0
    Start = 1'b0;
    repeat (31) step();              // after E31
    chk("b2b busy31", Busy, 1);
    MDOp = 3'd4; SrcA = 32'd9; SrcB = 32'd2; Start = 1'b1;
    step();                          // E32
    Start = 1'b0; MDOp = 3'd0;
    chk("b2b first lo", LO, 12);
    chk("b2b first hi", HI, 0);
    chk("b2b second busy", Busy, 1);
    repeat (31) step();              // after E63
    chk("b2b busy63", Busy, 1);
    chk("b2b lo63", LO, 12);
    step();                          // E64
    chk("b2b second lo", LO, 4);
    chk("b2b second hi", HI, 1);
    chk("b2b done", Busy, 0);

    // Reset in the middle of a MULT
    MDOp = 3'd1; SrcA = 32'h00012345; SrcB = 32'hFFFFF777; Start = 1'b1;
    step();
    Start = 1'b0; MDOp = 3'd0;
    repeat (9) step();
    reset = 1'b0;
    #1;
    chk("mid_rst busy", Busy, 0);
    chk("mid_rst hilo", {HI, LO}, 64'd0);
    step();
    step();
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      step();
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad = 1;
    end
    chk("post_rst quiet", bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic unit for the pipelined CPU. It extends the single-cycle ALU with a wider operation set, Zero and Overflow flags, and an iterative multiply/divide engine that owns the HI/LO registers. Integer ops stay combinational. Multiply and divide are multi-cycle and report progress through a Start/Busy handshake that the hazard unit uses to stall.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be a power of two, minimum 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  reset, asynchronous and active-low (0 = reset)
- SrcA  input  WIDTH  operand A; also the shift amount source for shifts
- SrcB  input  WIDTH  operand B
- ALUOp  input  4  combinational op select
- ALUResult  output  WIDTH  combinational result
- Zero  output  1  high when ALUResult == 0
- Overflow  output  1  signed overflow on ADD/SUB; 0 for all other ops
- MDOp  input  3  mul/div op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- Start  input  1  request to launch MDOp
- Busy  output  1  an iterative mul/div operation is in progress
- HI  output  WIDTH  HI register (product upper half / remainder)
- LO  output  WIDTH  LO register (product lower half / quotient)

## Operation
ALUOp encoding (purely combinational; no latches):
- 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLT (signed A<B gives 1, else 0), 6 SUB (A−B), 7 SLTU.
- 8 SLL, 9 SRL, 10 SRA: SrcB is shifted by SrcA[SHW-1:0].
- 11–15 produce ALUResult = 0.
- Overflow for ADD: operands have the same sign and the result sign differs. For SUB: operands have different signs and the result sign differs from A.

Mul/div engine FSM, states IDLE, MUL, DIV:
- IDLE with Start=1:
  - MDOp 1/2 goes to MUL.
  - MDOp 3/4 goes to DIV.
  - MDOp 5 writes HI=SrcA at that edge and stays IDLE; MDOp 6 writes LO=SrcA the same way.
  - MDOp 0/7 has no effect.
- Launch latches the operands, the signedness, and a step counter cleared to 0.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle, WIDTH iterations. Signed MULT negates the 2·WIDTH-bit product when the operand signs differ. Result: {HI,LO} = product.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations. Signed results take these signs:
  - quotient sign = sign(A) xor sign(B)
  - remainder sign = sign(A)
  - Result: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (SrcA as launched). Same duration as a normal divide; no exception.
- Signed MIN / −1: LO = MIN, HI = 0.
- On the final iteration, HI and LO are written together, and the FSM returns to IDLE.
- Start while Busy=1 is ignored. This includes MTHI/MTLO; the pipeline must stall instead.
- HI/LO keep their old values until the final write. Intermediate values never appear on HI/LO.

## Timing
- Reset (asynchronous, reset=0):
  - FSM goes to IDLE; Busy=0, HI=0, LO=0, counter=0.
  - Asserting reset mid-operation aborts it with no HI/LO write.
  - The first Start is accepted on the first rising edge after reset deasserts.
- ALUResult, Zero and Overflow are valid in the same cycle as their inputs (zero latency).
- MUL/DIV: Start is sampled at edge E0.
  - Busy goes high after E0 and stays high through edge E(WIDTH−1).
  - HI/LO update at edge E(WIDTH), and Busy drops at that same edge.
  - Latency is exactly WIDTH cycles, independent of operand values.
- A new Start may be accepted at E(WIDTH) and launches in the same cycle Busy falls. This must not conflict with the completing write: the new op only latches its operands, while HI/LO take the finishing result.
- MTHI/MTLO: one-edge write, Busy stays 0.
- Busy is a registered output.

## Test plan
- Reset: hold reset=0 and check HI=LO=0, Busy=0. Release reset, then apply ADD SrcA=0x7FFFFFFF, SrcB=1: ALUResult=0x80000000, Overflow=1, Zero=0.
- Combinational ops:
  - SLT A=0xFFFFFFFF, B=1 gives 1; SLTU with the same operands gives 0.
  - SRA A=4, B=0x80000000 gives 0xF8000000.
  - SUB 5−5 gives 0 with Zero=1.
  - ALUOp=13 gives 0.
- Multiply with A=0xFFFFFFFF, B=2:
  - MULT gives HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU gives HI=0x00000001, LO=0xFFFFFFFE.
  - Busy is high for exactly 32 cycles in each case.
- Divide:
  - DIV −7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU 7/0 gives LO=0xFFFFFFFF, HI=7.
- Handshake:
  - Start MTHI (SrcA=0x1234) while Busy: ignored, HI unchanged.
  - Back-to-back MULTU 3×4 then DIVU 9/2 with Start held high at E32: first gives LO=12; second gives LO=4, HI=1 at E64.
- Reset mid-op: assert reset=0 at cycle 10 of a MULT. Check Busy=0, HI=LO=0, and no later write after release.
